eth_pkt_gen: RTL and testbench

- Parametrised, runtime-configurable Ethernet test-frame generator that drives the eth_mac transmit byte stream.
- Replaces the fixed 64-byte ROM transmitter in the board top level.
- Supports configurable header, frame length, frame count, inter-frame gap and payload pattern.
- Sits between board control logic (buttons/switches/register FSM) and eth_mac tx_* ports. FCS is appended by the MAC, not here.

---
 rtl/eth_pkt_gen_pkg.sv | 33 +++
 rtl/eth_lfsr8.sv | 50 +++++
 rtl/eth_pkt_gen.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_eth_pkt_gen.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_gen_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkt_gen_pkg
// Shared definitions for the Ethernet test-frame generator and its helpers:
//   - payload mode encodings (mode_e)
//   - frame generator FSM states (state_e)
//   - ETH_HDR_LEN : bytes of dst + src + EtherType ahead of the payload
//   - LFSR_TAPS   : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - lfsr8_next  : one step of the 8-bit Fibonacci LFSR (shift toward MSB)
// ---------------------------------------------------------------------------
package eth_pkt_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC     = 2'd0,
        MODE_CONST   = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_INC_ALT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int ETH_HDR_LEN = 14;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/eth_lfsr8.sv
// ---------------------------------------------------------------------------
// eth_lfsr8
// 8-bit Fibonacci LFSR used for pseudo-random payload bytes. Shared with the
// receive-side checker so both ends produce the same sequence.
// Ports:
//   clk_mac in  clock
//   rst_n   in  asynchronous active-low reset
//   load    in  reload the register with seed (wins over adv)
//   seed    in  8-bit reload value, must be non-zero
//   adv     in  step the LFSR once
//   q       out current LFSR state
// ---------------------------------------------------------------------------
module eth_lfsr8
    import eth_pkt_gen_pkg::*;
(
    input  logic       clk_mac,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next state: reload has priority over advance
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (adv) begin
            q_d = lfsr8_next(q_q);
        end else begin
            q_d = q_q;
        end
    end

    // LFSR state register; non-zero reset value keeps it out of the lock-up state
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 8'h01;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/eth_pkt_gen.sv
// ---------------------------------------------------------------------------
// eth_pkt_gen
// Runtime-configurable Ethernet test-frame generator feeding the MAC transmit
// byte stream (FCS is appended by the MAC). A start pulse latches cfg_* and
// sends cfg_count frames (0 = until stop) with cfg_gap idle cycles between.
// Ports:
//   clk_mac, rst_n            clock, asynchronous active-low reset
//   start, stop               one-cycle control pulses
//   cfg_len/count/gap/mode    frame length, frames per burst, gap, pattern
//   cfg_dst/src/type/fill     header fields and constant-mode byte
//   tx_vld/dat/sof/eof        registered byte stream to the MAC
//   tx_ack                    MAC accepted the presented byte
//   busy, done, sent_cnt      burst status
// Build option: define ETH_PKT_GEN_SEQ_EN to place a 16-bit big-endian
// sequence number in bytes 14-15 (minimum length then becomes 16).
// ---------------------------------------------------------------------------
module eth_pkt_gen
    import eth_pkt_gen_pkg::*;
#(
    parameter int         MAX_LEN   = 1514,
    parameter int         LEN_W     = 11,
    parameter int         CNT_W     = 16,
    parameter int         GAP_W     = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic             clk_mac,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [1:0]       cfg_mode,
    input  logic [47:0]      cfg_dst,
    input  logic [47:0]      cfg_src,
    input  logic [15:0]      cfg_type,
    input  logic [7:0]       cfg_fill,
    output logic             tx_vld,
    output logic [7:0]       tx_dat,
    output logic             tx_sof,
    output logic             tx_eof,
    input  logic             tx_ack,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_cnt
);

`ifdef ETH_PKT_GEN_SEQ_EN
    localparam int MIN_LEN = ETH_HDR_LEN + 2;
`else
    localparam int MIN_LEN = ETH_HDR_LEN;
`endif
    localparam logic [LEN_W-1:0] MIN_LEN_W = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] HDR_W     = LEN_W'(ETH_HDR_LEN);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [47:0]      dst_q, dst_d, src_q, src_d;
    logic [15:0]      type_q, type_d;
    logic [7:0]       fill_q, fill_d;
    logic [CNT_W-1:0] count_q, count_d, sent_q, sent_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0] last_q, last_d, idx_q, idx_d;
    logic             stop_pend_q, stop_pend_d, busy_q, busy_d, done_q, done_d;
    logic             vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
    logic [7:0]       dat_q, dat_d;

    logic             acc_s, count_hit_s, issue_s, drop_s;
    logic [LEN_W-1:0] issue_idx_s, eff_len_s;
    logic [CNT_W-1:0] sent_inc_s;
    logic [7:0]       next_byte_s, pay_byte_s, lfsr_s;
    logic             lfsr_load_s, lfsr_adv_s;
`ifdef ETH_PKT_GEN_SEQ_EN
    logic [15:0]      seq_s;
    assign seq_s = 16'(sent_q);
`endif

    assign acc_s       = vld_q & tx_ack;
    assign sent_inc_s  = sent_q + CNT_W'(1);
    assign count_hit_s = (count_q != CNT_W'(0)) && (sent_inc_s == count_q);
    // The LFSR is reseeded while header bytes go out and steps once per
    // payload byte, so it holds the value for the next payload byte.
    assign lfsr_load_s = issue_s && (issue_idx_s < HDR_W);
    assign lfsr_adv_s  = issue_s && !(issue_idx_s < HDR_W);
    assign pay_byte_s  = 8'(issue_idx_s - HDR_W);

    eth_lfsr8 u_lfsr (
        .clk_mac (clk_mac),
        .rst_n   (rst_n),
        .load    (lfsr_load_s),
        .seed    (LFSR_SEED),
        .adv     (lfsr_adv_s),
        .q       (lfsr_s)
    );

    // Clamp the requested length to the legal frame size range
    always_comb begin
        if (cfg_len < MIN_LEN_W) begin
            eff_len_s = MIN_LEN_W;
        end else if (cfg_len > MAX_LEN_W) begin
            eff_len_s = MAX_LEN_W;
        end else begin
            eff_len_s = cfg_len;
        end
    end

    // Burst/frame sequencing and configuration latching
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        fill_d      = fill_q;
        count_d     = count_q;
        gap_d       = gap_q;
        last_d      = last_q;
        sent_d      = sent_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        issue_s     = 1'b0;
        issue_idx_s = LEN_W'(0);
        drop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode_e'(cfg_mode);
                    dst_d       = cfg_dst;
                    src_d       = cfg_src;
                    type_d      = cfg_type;
                    fill_d      = cfg_fill;
                    count_d     = cfg_count;
                    gap_d       = cfg_gap;
                    last_d      = eff_len_s - LEN_W'(1);
                    sent_d      = CNT_W'(0);
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SEND;
                    issue_s     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (acc_s && eof_q) begin
                    sent_d = sent_inc_s;
                    // A stop arriving with the final ack still ends the burst here
                    if (count_hit_s || stop_pend_q || stop) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                        drop_s      = 1'b1;
                    end else if (gap_q != GAP_W'(0)) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                        drop_s    = 1'b1;
                    end else begin
                        issue_s = 1'b1;
                    end
                end else if (acc_s) begin
                    issue_s     = 1'b1;
                    issue_idx_s = idx_q + LEN_W'(1);
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = ST_SEND;
                    issue_s = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                drop_s  = 1'b1;
            end
        endcase
    end

    // Byte value for the position about to be presented; uses the *_d header
    // copies so the first byte can go out on the same edge that latches cfg_*
    always_comb begin
        next_byte_s = 8'h00;
        case (issue_idx_s)
            LEN_W'(0):  next_byte_s = dst_d[47:40];
            LEN_W'(1):  next_byte_s = dst_d[39:32];
            LEN_W'(2):  next_byte_s = dst_d[31:24];
            LEN_W'(3):  next_byte_s = dst_d[23:16];
            LEN_W'(4):  next_byte_s = dst_d[15:8];
            LEN_W'(5):  next_byte_s = dst_d[7:0];
            LEN_W'(6):  next_byte_s = src_d[47:40];
            LEN_W'(7):  next_byte_s = src_d[39:32];
            LEN_W'(8):  next_byte_s = src_d[31:24];
            LEN_W'(9):  next_byte_s = src_d[23:16];
            LEN_W'(10): next_byte_s = src_d[15:8];
            LEN_W'(11): next_byte_s = src_d[7:0];
            LEN_W'(12): next_byte_s = type_d[15:8];
            LEN_W'(13): next_byte_s = type_d[7:0];
`ifdef ETH_PKT_GEN_SEQ_EN
            LEN_W'(14): next_byte_s = seq_s[15:8];
            LEN_W'(15): next_byte_s = seq_s[7:0];
`endif
            default: begin
                case (mode_d)
                    MODE_CONST: next_byte_s = fill_d;
                    MODE_LFSR:  next_byte_s = lfsr_s;
                    default:    next_byte_s = pay_byte_s;
                endcase
            end
        endcase
    end

    // Output stage next values: present a new byte, drop valid, or hold
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        sof_d = sof_q;
        eof_d = eof_q;
        idx_d = idx_q;
        if (issue_s) begin
            vld_d = 1'b1;
            dat_d = next_byte_s;
            sof_d = (issue_idx_s == LEN_W'(0));
            eof_d = (issue_idx_s == last_d);
            idx_d = issue_idx_s;
        end else if (drop_s) begin
            vld_d = 1'b0;
            dat_d = 8'h00;
            sof_d = 1'b0;
            eof_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // State, configuration and output registers
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_INC;
            dst_q       <= 48'h0;
            src_q       <= 48'h0;
            type_q      <= 16'h0;
            fill_q      <= 8'h00;
            count_q     <= CNT_W'(0);
            gap_q       <= GAP_W'(0);
            last_q      <= LEN_W'(0);
            sent_q      <= CNT_W'(0);
            gap_cnt_q   <= GAP_W'(0);
            idx_q       <= LEN_W'(0);
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= 1'b0;
            dat_q       <= 8'h00;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            last_q      <= last_d;
            sent_q      <= sent_d;
            gap_cnt_q   <= gap_cnt_d;
            idx_q       <= idx_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            dat_q       <= dat_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

    assign tx_vld   = vld_q;
    assign tx_dat   = dat_q;
    assign tx_sof   = sof_q;
    assign tx_eof   = eof_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sent_cnt = sent_q;

endmodule

// File: tb/tb_eth_pkt_gen.sv
// ---------------------------------------------------------------------------
// tb_eth_pkt_gen
// Self-checking bench for eth_pkt_gen. A frame model builds the expected byte
// stream (header fields, clamped length, payload pattern) into a queue; a
// per-cycle monitor pops it on every accepted byte, checks stall stability
// and inter-frame gap length. Directed tests cover the main scenarios.
// ---------------------------------------------------------------------------
module tb_eth_pkt_gen;

`ifdef ETH_PKT_GEN_SEQ_EN
    localparam int MINL = 16;
    localparam bit SEQ  = 1'b1;
`else
    localparam int MINL = 14;
    localparam bit SEQ  = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [10:0] cfg_len;
    logic [15:0] cfg_count;
    logic [15:0] cfg_gap;
    logic [1:0]  cfg_mode;
    logic [47:0] cfg_dst;
    logic [47:0] cfg_src;
    logic [15:0] cfg_type;
    logic [7:0]  cfg_fill;
    logic        tx_vld;
    logic [7:0]  tx_dat;
    logic        tx_sof;
    logic        tx_eof;
    logic        tx_ack;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;

    eth_pkt_gen dut (
        .clk_mac   (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cfg_len   (cfg_len),
        .cfg_count (cfg_count),
        .cfg_gap   (cfg_gap),
        .cfg_mode  (cfg_mode),
        .cfg_dst   (cfg_dst),
        .cfg_src   (cfg_src),
        .cfg_type  (cfg_type),
        .cfg_fill  (cfg_fill),
        .tx_vld    (tx_vld),
        .tx_dat    (tx_dat),
        .tx_sof    (tx_sof),
        .tx_eof    (tx_eof),
        .tx_ack    (tx_ack),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_total = 0;
    int done_total = 0;
    int sof_cyc = 0;
    int eof_cyc = 0;
    int low_run = 0;
    int exp_gap = 0;
    bit pending_gap = 1'b0;
    bit prev_stall = 1'b0;
    bit ack_toggle = 1'b0;
    logic [9:0] prev_bus;
    logic [9:0] exp_q[$];

    localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Spec LFSR: feedback from polynomial terms x^8, x^6, x^5, x^4
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    // Append one expected frame: {sof, eof, byte} per position
    task automatic push_frame(input int len, input int mode, input logic [47:0] dst,
                              input logic [15:0] typ, input logic [7:0] fill, input int seq);
        int L;
        logic [7:0] lf;
        logic [7:0] b;
        logic [15:0] sq;
        int k;
        L  = (len < MINL) ? MINL : ((len > 1514) ? 1514 : len);
        lf = 8'hA5;
        sq = 16'(seq);
        for (int i = 0; i < L; i++) begin
            if (i < 6)       b = dst[47 - 8*i -: 8];
            else if (i < 12) b = SRC[47 - 8*(i-6) -: 8];
            else if (i == 12) b = typ[15:8];
            else if (i == 13) b = typ[7:0];
            else begin
                k = i - 14;
                if (SEQ && k == 0)      b = sq[15:8];
                else if (SEQ && k == 1) b = sq[7:0];
                else if (mode == 1)     b = fill;
                else if (mode == 2)     b = lf;
                else                    b = 8'(k);
                lf = lfsr_step(lf);
            end
            exp_q.push_back({(i == 0), (i == L-1), b});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_burst(input int len, input int cnt, input int gap, input int mode,
                               input logic [47:0] dst, input logic [15:0] typ, input logic [7:0] fill);
        tick();
        cfg_len   = 11'(len);
        cfg_count = 16'(cnt);
        cfg_gap   = 16'(gap);
        cfg_mode  = 2'(mode);
        cfg_dst   = dst;
        cfg_src   = SRC;
        cfg_type  = typ;
        cfg_fill  = fill;
        exp_gap   = gap;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int d0;
        int n;
        d0 = done_total;
        n  = 0;
        while (done_total == d0 && n < maxc) begin
            tick();
            n++;
        end
        check(nm, 32'(done_total != d0), 32'd1);
    endtask

    task automatic wait_acc(input string nm, input int target, input int maxc);
        int n;
        n = 0;
        while (acc_total < target && n < maxc) begin
            tick();
            n++;
        end
        check(nm, 32'(acc_total >= target), 32'd1);
    endtask

    // MAC acknowledge: always 1, or alternating when ack_toggle is set
    initial begin
        tx_ack = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ack_toggle) tx_ack = ~tx_ack;
            else            tx_ack = 1'b1;
        end
    end

    // Per-cycle monitor against the frame model
    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall  = 1'b0;
                pending_gap = 1'b0;
            end else begin
                if (done) begin
                    done_total++;
                    pending_gap = 1'b0;
                end
                if (prev_stall)
                    check("stall_hold", {tx_vld, tx_sof, tx_eof, tx_dat}, {1'b1, prev_bus});
                if (pending_gap) begin
                    if (!tx_vld) low_run++;
                    else begin
                        check("gap_len", 32'(low_run), 32'(exp_gap));
                        pending_gap = 1'b0;
                    end
                end
                if (tx_vld && tx_ack) begin
                    acc_total++;
                    check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("byte", {tx_sof, tx_eof, tx_dat}, e);
                    end
                    if (tx_sof) sof_cyc = cyc;
                    if (tx_eof) begin
                        eof_cyc     = cyc;
                        pending_gap = 1'b1;
                        low_run     = 0;
                    end
                end
                prev_stall = tx_vld && !tx_ack;
                prev_bus   = {tx_sof, tx_eof, tx_dat};
            end
        end
    end

    initial begin : main
        int base;
        int d0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_len = 11'd0; cfg_count = 16'd0; cfg_gap = 16'd0; cfg_mode = 2'd0;
        cfg_dst = 48'h0; cfg_src = 48'h0; cfg_type = 16'h0; cfg_fill = 8'h00;
        repeat (3) tick();
        check("rst_vld", tx_vld, 1'b0);
        check("rst_bus", {tx_sof, tx_eof, tx_dat}, 10'h000);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_sent", sent_cnt, 16'd0);
        rst_n = 1'b1;
        tick();

        // LFSR model pinned by hand-stepped values
        check("model_lfsr_a5", lfsr_step(8'hA5), 8'h4A);
        check("model_lfsr_4a", lfsr_step(8'h4A), 8'h95);

        // stop while idle does nothing
        stop = 1'b1; tick(); stop = 1'b0; tick();
        check("stop_idle_busy", {busy, done}, 2'b00);

        // T1: one 64-byte incrementing frame, continuous ack
        push_frame(64, 0, 48'hFFFF_FFFF_FFFF, 16'hEBEB, 8'h00, 0);
        check("model_b0", exp_q[0], {2'b10, 8'hFF});
        check("model_b12", exp_q[12], {2'b00, 8'hEB});
        check("model_b14", exp_q[14], {2'b00, 8'h00});
        check("model_b63", exp_q[63], {2'b01, 8'h31});
        base = acc_total; d0 = done_total;
        start_burst(64, 1, 0, 0, 48'hFFFF_FFFF_FFFF, 16'hEBEB, 8'h00);
        check("t1_busy", busy, 1'b1);
        wait_done("t1_done", 200);
        repeat (4) tick();
        check("t1_bytes", 32'(acc_total - base), 32'd64);
        check("t1_sof_to_eof", 32'(eof_cyc - sof_cyc), 32'd63);
        check("t1_done_once", 32'(done_total - d0), 32'd1);
        check("t1_sent", sent_cnt, 16'd1);
        check("t1_busy_end", busy, 1'b0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // T2: alternating ack, 20-byte constant frame
        ack_toggle = 1'b1;
        push_frame(20, 1, 48'h0A0B_0C0D_0E0F, 16'h0800, 8'h5A, 0);
        base = acc_total;
        start_burst(20, 1, 0, 1, 48'h0A0B_0C0D_0E0F, 16'h0800, 8'h5A);
        wait_done("t2_done", 200);
        ack_toggle = 1'b0;
        repeat (3) tick();
        check("t2_bytes", 32'(acc_total - base), 32'd20);
        check("t2_sent", sent_cnt, 16'd1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // T3: three frames, gap 5; a mid-burst start with new cfg is ignored
        for (int f = 0; f < 3; f++) push_frame(16, 0, 48'h1111_2222_3333, 16'h88B5, 8'h00, f);
        base = acc_total;
        start_burst(16, 3, 5, 0, 48'h1111_2222_3333, 16'h88B5, 8'h00);
        wait_acc("t3_reach", base + 20, 200);
        cfg_len = 11'd40; cfg_mode = 2'd1; cfg_gap = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t3_done", 300);
        tick();
        check("t3_sent", sent_cnt, 16'd3);
        check("t3_busy", busy, 1'b0);
        check("t3_bytes", 32'(acc_total - base), 32'd48);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // T4: continuous, stop at byte 30 of frame 4
        for (int f = 0; f < 4; f++) push_frame(60, 1, 48'hDEAD_BEEF_0001, 16'h1234, 8'hC3, f);
        base = acc_total;
        start_burst(60, 0, 0, 1, 48'hDEAD_BEEF_0001, 16'h1234, 8'hC3);
        wait_acc("t4_reach", base + 210, 400);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_done("t4_done", 200);
        repeat (3) tick();
        check("t4_sent", sent_cnt, 16'd4);
        check("t4_bytes", 32'(acc_total - base), 32'd240);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // T5: LFSR payload repeats per frame
        push_frame(18, 2, 48'h0000_0000_0001, 16'h9000, 8'h00, 0);
        check("model_lfsr_b16", exp_q[16], {2'b00, 8'h95});
        check("model_lfsr_b17", exp_q[17], {2'b01, 8'h2A});
`ifndef ETH_PKT_GEN_SEQ_EN
        check("model_lfsr_b14", exp_q[14], {2'b00, 8'hA5});
        check("model_lfsr_b15", exp_q[15], {2'b00, 8'h4A});
`endif
        push_frame(18, 2, 48'h0000_0000_0001, 16'h9000, 8'h00, 1);
        start_burst(18, 2, 2, 2, 48'h0000_0000_0001, 16'h9000, 8'h00);
        wait_done("t5_done", 200);
        tick();
        check("t5_sent", sent_cnt, 16'd2);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // T6: stop during gap ends the burst immediately
        push_frame(14, 0, 48'hAAAA_BBBB_CCCC, 16'h0806, 8'h00, 0);
        base = acc_total;
        start_burst(14, 0, 20, 0, 48'hAAAA_BBBB_CCCC, 16'h0806, 8'h00);
        wait_acc("t6_reach", base + MINL, 100);
        repeat (2) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        check("t6_done_now", {done, busy}, 2'b10);
        check("t6_sent", sent_cnt, 16'd1);
        repeat (25) tick();
        check("t6_no_more", 32'(acc_total - base), 32'(MINL));

        // T7: reset mid-frame, then a clean frame
        push_frame(64, 0, 48'h0102_0304_0506, 16'hEBEB, 8'h00, 0);
        base = acc_total;
        start_burst(64, 1, 0, 0, 48'h0102_0304_0506, 16'hEBEB, 8'h00);
        wait_acc("t7_reach", base + 10, 100);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_vld", tx_vld, 1'b0);
        check("t7_async_busy", busy, 1'b0);
        check("t7_async_sent", sent_cnt, 16'd0);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        push_frame(30, 1, 48'h0102_0304_0506, 16'hEBEB, 8'h77, 0);
        base = acc_total;
        start_burst(30, 1, 0, 1, 48'h0102_0304_0506, 16'hEBEB, 8'h77);
        wait_done("t7_done", 200);
        tick();
        check("t7_bytes", 32'(acc_total - base), 32'd30);
        check("t7_sent", sent_cnt, 16'd1);
        check("t7_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
